branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 84 ++++++++
 tb/tb_branch_resolve_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates a RISC-V conditional branch, registers the
// resolved direction/target behind a single-entry output stage, and counts branches.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  next_pc,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Input side accepts when in_valid && in_ready && !flush; output side
  // releases the entry when out_valid && out_ready. out_valid never drops
  // without a transfer except on flush or reset.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            accept;
  logic            eq, lt_s, lt_u, cond;
  logic            res_illegal, res_taken, res_mispredict;
  logic [XLEN-1:0] res_next_pc;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    eq   = (rs1_val == rs2_val);
    lt_s = ($signed(rs1_val) < $signed(rs2_val));
    lt_u = (rs1_val < rs2_val);
    // funct3[2:1] selects the comparison, funct3[0] inverts it.
    unique case (funct3[2:1])
      2'b00:   cond = eq;
      2'b10:   cond = lt_s;
      2'b11:   cond = lt_u;
      default: cond = 1'b0;
    endcase
    res_illegal    = (funct3[2:1] == 2'b01);
    res_taken      = (cond ^ funct3[0]) && !res_illegal;
    res_mispredict = res_taken ^ pred_taken;
    res_next_pc    = pc + (res_taken ? imm : XLEN'(4));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      taken      <= 1'b0;
      mispredict <= 1'b0;
      illegal    <= 1'b0;
      next_pc    <= '0;
      br_cnt     <= '0;
      mis_cnt    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      taken      <= res_taken;
      mispredict <= res_mispredict;
      illegal    <= res_illegal;
      next_pc    <= res_next_pc;
      if (!res_illegal && br_cnt != CNT_MAX) br_cnt <= br_cnt + 1'b1;
      if (res_mispredict && mis_cnt != CNT_MAX) mis_cnt <= mis_cnt + 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed branch cases,
// backpressure, flush, illegal codes, counter saturation and reset.
module tb_branch_resolve_unit;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;
  localparam int EW    = 3 + XLEN + 2 * CNT_W;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_val, rs2_val, pc, imm;
  logic             pred_taken;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic [XLEN-1:0]  next_pc;
  logic             mispredict;
  logic             illegal;
  logic [CNT_W-1:0] br_cnt, mis_cnt;

  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] m_br, m_mis;
  int               n_cmp = 0;
  int               n_err = 0;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .next_pc(next_pc),
    .mispredict(mispredict), .illegal(illegal), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: returns {illegal, taken}
  function automatic logic [1:0] ref_resolve(input logic [2:0] f3,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    case (f3)
      3'b000:  return {1'b0, a == b};
      3'b001:  return {1'b0, a != b};
      3'b100:  return {1'b0, $signed(a) <  $signed(b)};
      3'b101:  return {1'b0, $signed(a) >= $signed(b)};
      3'b110:  return {1'b0, a <  b};
      3'b111:  return {1'b0, a >= b};
      default: return 2'b10;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    in_valid   = 1'b0;
    funct3     = 3'($urandom_range(0, 7));
    rs1_val    = $urandom;
    rs2_val    = $urandom;
    pc         = $urandom;
    imm        = $urandom;
    pred_taken = 1'($urandom_range(0, 1));
  endtask

  // Presents one request and returns at posedge+1 after it is accepted.
  task automatic send(input logic [2:0] f3, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [XLEN-1:0] p,
                      input logic [XLEN-1:0] i, input logic pr);
    logic [1:0]      r;
    logic            mis;
    logic [XLEN-1:0] nx;
    bit              ok;
    int              stalls;
    in_valid = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; pc = p; imm = i; pred_taken = pr;
    ok = 0;
    stalls = 0;
    while (!ok && stalls < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin
        stalls++;
        @(posedge clk);
        #1;
        if (stalls >= 2) out_ready = 1'b1;
      end
    end
    check("send_accept_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    if (ok) begin
      r   = ref_resolve(f3, a, b);
      mis = r[0] ^ pr;
      nx  = r[0] ? p + i : p + 32'd4;
      if (!r[1] && m_br != CMAX) m_br = m_br + 1'b1;
      if (mis && m_mis != CMAX) m_mis = m_mis + 1'b1;
      exp_q.push_back({r[0], mis, r[1], nx, m_br, m_mis});
    end
    #1;
    idle_inputs();
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    exp_q.delete();
    m_br  = '0;
    m_mis = '0;
    rst   = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("taken",      64'(taken),      64'(e[EW-1]));
        check("mispredict", 64'(mispredict), 64'(e[EW-2]));
        check("illegal",    64'(illegal),    64'(e[EW-3]));
        check("next_pc",    64'(next_pc),    64'(e[2*CNT_W +: XLEN]));
        check("br_cnt",     64'(br_cnt),     64'(e[CNT_W +: CNT_W]));
        check("mis_cnt",    64'(mis_cnt),    64'(e[0 +: CNT_W]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [XLEN-1:0] a, b;
    flush     = 1'b0;
    out_ready = 1'b1;
    m_br      = '0;
    m_mis     = '0;
    // A request held during reset must be discarded.
    in_valid = 1'b1; funct3 = 3'b000; rs1_val = 0; rs2_val = 0;
    pc = 32'h40; imm = 32'h8; pred_taken = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_taken",     64'(taken),     64'd0);
    check("rst_next_pc",   64'(next_pc),   64'd0);
    check("rst_mis",       64'(mispredict), 64'd0);
    check("rst_illegal",   64'(illegal),   64'd0);
    check("rst_br_cnt",    64'(br_cnt),    64'd0);
    check("rst_mis_cnt",   64'(mis_cnt),   64'd0);
    @(posedge clk); #1;

    // Signed vs unsigned less-than on the same operands.
    send(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    @(negedge clk);
    check("blt_taken",   64'(taken),   64'd1);
    check("blt_next_pc", 64'(next_pc), 64'h120);
    check("blt_br_cnt",  64'(br_cnt),  64'd1);
    check("blt_mis_cnt", 64'(mis_cnt), 64'd1);
    @(posedge clk); #1;
    send(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    @(negedge clk);
    check("bltu_next_pc", 64'(next_pc), 64'h104);
    @(posedge clk); #1;

    // PC wrap-around, back-to-back requests.
    send(3'b000, 32'h55, 32'h55, 32'hFFFF_FFFC, 32'h8, 1'b1);
    send(3'b001, 32'h55, 32'h55, 32'hFFFF_FFFC, 32'h8, 1'b0);
    @(negedge clk);
    check("bne_wrap_next_pc", 64'(next_pc), 64'h0);
    @(posedge clk); #1;

    // Backpressure: result held, in_ready low, then replaced back-to-back.
    out_ready = 1'b0;
    send(3'b101, 32'h3, 32'h7, 32'h2000, 32'hFFFF_FFF0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_next_pc",   64'(next_pc),   64'h2004);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'b111, 32'h9, 32'h9, 32'h3000, 32'h40, 1'b0);
    @(negedge clk);
    check("b2b_out_valid", 64'(out_valid), 64'd1);
    check("b2b_next_pc",   64'(next_pc),   64'h3040);
    @(posedge clk); #1;

    // Illegal code with prediction taken.
    send(3'b010, 32'h1, 32'h2, 32'h500, 32'h10, 1'b1);
    @(negedge clk);
    check("ill_illegal", 64'(illegal), 64'd1);
    check("ill_taken",   64'(taken),   64'd0);
    @(posedge clk); #1;

    // Flush with a held result and a same-cycle request.
    out_ready = 1'b0;
    send(3'b000, 32'h1, 32'h1, 32'h600, 32'h10, 1'b0);
    flush = 1'b1; in_valid = 1'b1; funct3 = 3'b001;
    rs1_val = 32'h1; rs2_val = 32'h2; pc = 32'h700; imm = 32'h4; pred_taken = 1'b0;
    @(posedge clk);
    exp_q.delete();
    #1;
    flush = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_br_cnt",    64'(br_cnt),    64'(m_br));
    check("flush_mis_cnt",   64'(mis_cnt),   64'(m_mis));
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Counter saturation from a clean state.
    apply_reset(1);
    for (int k = 0; k < 5; k++) send(3'b000, 32'h4, 32'h5, 32'h800, 32'h20, 1'b1);
    @(negedge clk);
    check("sat_mis_cnt", 64'(mis_cnt), 64'(CMAX));
    @(posedge clk); #1;

    // Random traffic with random gaps and consumer stalls.
    for (int k = 0; k < 40; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      send(3'($urandom_range(0, 7)), a, b, $urandom, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset while a result is held.
    out_ready = 1'b0;
    send(3'b100, 32'h8000_0000, 32'h0, 32'h900, 32'h40, 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_taken",     64'(taken),     64'd0);
    check("rst2_next_pc",   64'(next_pc),   64'd0);
    check("rst2_mis",       64'(mispredict), 64'd0);
    check("rst2_br_cnt",    64'(br_cnt),    64'd0);
    check("rst2_mis_cnt",   64'(mis_cnt),   64'd0);
    exp_q.delete();
    m_br = '0; m_mis = '0;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_in_ready", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
